traffic_phase_sequencer: RTL and testbench

Upstream control stage for traffic_light_dataflow. It produces the phase code {s0,s1,s2} and the manual-mode flag m that the light decoder consumes. Automatic mode runs timed phases, with the side-street green granted only on a latched car request. Manual mode advances phases on a debounced operator step button.

---
 rtl/traffic_phase_sequencer_if.sv | 22 ++
 rtl/traffic_phase_sequencer.sv | 167 ++++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the phase sequencer and its environment: raw operator
// and sensor inputs in, registered phase code / mode / request flags out.
interface traffic_phase_sequencer_if;
  logic car_sensor;
  logic man_btn;
  logic man_step;
  logic m;
  logic s0;
  logic s1;
  logic s2;
  logic req_pending;

  modport master (
    output car_sensor, man_btn, man_step,
    input  m, s0, s1, s2, req_pending
  );

  modport slave (
    input  car_sensor, man_btn, man_step,
    output m, s0, s1, s2, req_pending
  );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Traffic phase sequencer: timed auto phases with latched side-street request,
// manual stepping on a debounced operator button.
//
// state       | meaning
// MAIN_GREEN  | main street green, dwell saturates until a request is latched
// MAIN_YELLOW | main street yellow, T_Y cycles
// ALL_RED_A   | all red before side green, T_AR cycles
// SIDE_GREEN  | side street green, T_SG cycles; entry clears the request
// SIDE_YELLOW | side street yellow, T_Y cycles
// ALL_RED_B   | all red before main green, T_AR cycles
module traffic_phase_sequencer #(
  parameter int T_MG_MIN = 8,
  parameter int T_Y      = 3,
  parameter int T_AR     = 1,
  parameter int T_SG     = 6,
  parameter int DEB      = 4,
  parameter int CW       = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  traffic_phase_sequencer_if.slave   bus
);

  localparam int DW = (DEB > 1) ? $clog2(DEB) : 1;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } phase_t;

  // bit 0 car_sensor, bit 1 man_btn, bit 2 man_step
  logic [2:0]    r_sync1;
  logic [2:0]    r_sync2;
  // index 0 man_btn, index 1 man_step
  logic [1:0]    r_deb;
  logic [DW-1:0] r_dcnt [2];
  logic [1:0]    w_db_in;
  logic [1:0]    w_db_hit;
  logic [1:0]    w_pulse;

  phase_t        r_phase, w_phase_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_m, w_m_nxt;
  logic          r_req, w_req_nxt;
  logic          w_last;
  logic          w_enter_sg;

  function automatic phase_t f_next(input phase_t p);
    case (p)
      MAIN_GREEN:  f_next = MAIN_YELLOW;
      MAIN_YELLOW: f_next = ALL_RED_A;
      ALL_RED_A:   f_next = SIDE_GREEN;
      SIDE_GREEN:  f_next = SIDE_YELLOW;
      SIDE_YELLOW: f_next = ALL_RED_B;
      default:     f_next = MAIN_GREEN;
    endcase
  endfunction

  function automatic logic [CW-1:0] f_last(input phase_t p);
    case (p)
      MAIN_GREEN:              f_last = CW'(T_MG_MIN - 1);
      MAIN_YELLOW, SIDE_YELLOW: f_last = CW'(T_Y - 1);
      ALL_RED_A, ALL_RED_B:    f_last = CW'(T_AR - 1);
      SIDE_GREEN:              f_last = CW'(T_SG - 1);
      default:                 f_last = '0;
    endcase
  endfunction

  // Two-flop synchronizers for all three raw inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {bus.man_step, bus.man_btn, bus.car_sensor};
      r_sync2 <= r_sync1;
    end
  end

  assign w_db_in = r_sync2[2:1];

  // Debounce acceptance: the DEB-th consecutive differing sample commits the level,
  // and a rising commit is the single-cycle pulse consumed on that same edge
  always_comb begin
    w_db_hit = '0;
    w_pulse  = '0;
    for (int i = 0; i < 2; i++) begin
      w_db_hit[i] = (w_db_in[i] != r_deb[i]) && (r_dcnt[i] == DW'(DEB - 1));
      w_pulse[i]  = w_db_hit[i] & w_db_in[i];
    end
  end

  // Debounce stability counters and committed levels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb <= '0;
      for (int i = 0; i < 2; i++) r_dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_db_in[i] == r_deb[i]) begin
          r_dcnt[i] <= '0;
        end else if (w_db_hit[i]) begin
          r_deb[i]  <= w_db_in[i];
          r_dcnt[i] <= '0;
        end else begin
          r_dcnt[i] <= r_dcnt[i] + DW'(1);
        end
      end
    end
  end

  assign w_last = (r_cnt == f_last(r_phase));

  // Next phase, dwell counter and mode; mode toggle outranks a coincident step
  always_comb begin
    w_phase_nxt = r_phase;
    w_cnt_nxt   = r_cnt;
    w_m_nxt     = r_m;
    if (r_phase > ALL_RED_B) begin
      w_phase_nxt = MAIN_GREEN;
      w_cnt_nxt   = '0;
    end else if (w_pulse[0]) begin
      w_m_nxt   = ~r_m;
      w_cnt_nxt = '0;
    end else if (r_m) begin
      w_cnt_nxt = '0;
      if (w_pulse[1]) w_phase_nxt = f_next(r_phase);
    end else if (w_last) begin
      // main green holds at its minimum until a request is pending
      if ((r_phase != MAIN_GREEN) || r_req) begin
        w_phase_nxt = f_next(r_phase);
        w_cnt_nxt   = '0;
      end
    end else begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  assign w_enter_sg = (w_phase_nxt == SIDE_GREEN) && (r_phase != SIDE_GREEN);
  assign w_req_nxt  = w_enter_sg ? 1'b0 : (r_req | r_sync2[0]);

  // Phase, counter, mode and request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= MAIN_GREEN;
      r_cnt   <= '0;
      r_m     <= 1'b0;
      r_req   <= 1'b0;
    end else begin
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_m     <= w_m_nxt;
      r_req   <= w_req_nxt;
    end
  end

  assign bus.s0          = r_phase[2];
  assign bus.s1          = r_phase[1];
  assign bus.s2          = r_phase[0];
  assign bus.m           = r_m;
  assign bus.req_pending = r_req;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scoreboard bench for traffic_phase_sequencer at default parameters.
// Observed word is {m, s0, s1, s2, req_pending}.
module tb_traffic_phase_sequencer;

  localparam int T_MG_MIN = 8;
  localparam int T_Y      = 3;
  localparam int T_AR     = 1;
  localparam int T_SG     = 6;
  localparam int DEB      = 4;
  localparam int LAT      = 2 + DEB;

  typedef struct {
    string      tag;
    logic [4:0] val;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  sb_t  sb_q[$];
  logic [2:0] exp_ph;

  traffic_phase_sequencer_if bus ();

  traffic_phase_sequencer #(
    .T_MG_MIN (T_MG_MIN),
    .T_Y      (T_Y),
    .T_AR     (T_AR),
    .T_SG     (T_SG),
    .DEB      (DEB),
    .CW       (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {bus.m, bus.s0, bus.s1, bus.s2, bus.req_pending};
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b expected %b ({m,s0,s1,s2,req})", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input string tag, input logic m, input logic [2:0] ph, input logic req);
    sb_t e;
    e.tag = tag;
    e.val = {m, ph, req};
    sb_q.push_back(e);
  endtask

  // phase reached t cycles after entering MAIN_GREEN, one full cycle then back to 000
  function automatic logic [2:0] seq_phase(input int t);
    int b1, b2, b3, b4, b5, b6;
    b1 = T_MG_MIN;
    b2 = b1 + T_Y;
    b3 = b2 + T_AR;
    b4 = b3 + T_SG;
    b5 = b4 + T_Y;
    b6 = b5 + T_AR;
    if (t < b1) return 3'd0;
    if (t < b2) return 3'd1;
    if (t < b3) return 3'd2;
    if (t < b4) return 3'd3;
    if (t < b5) return 3'd4;
    if (t < b6) return 3'd5;
    return 3'd0;
  endfunction

  // Compare every expectation pushed this cycle, well away from the clock edge
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check(e.tag, obs(), e.val);
    end
  end

  task automatic press_step();
    bus.man_step = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == LAT) exp_ph = (exp_ph == 3'd5) ? 3'd0 : exp_ph + 3'd1;
      push("man_step", 1'b1, exp_ph, 1'b0);
      if (i == LAT) bus.man_step = 1'b0;
    end
  endtask

  initial begin
    bus.car_sensor = 1'b0;
    bus.man_btn    = 1'b0;
    bus.man_step   = 1'b0;
    exp_ph         = 3'd0;
    tick();
    tick();
    rst = 1'b0;

    // Build up a non-reset state, then reset asynchronously mid-cycle
    bus.car_sensor = 1'b1;
    repeat (10) tick();
    bus.car_sensor = 1'b0;
    check("pre_rst_state", obs(), 5'b0_001_1);
    #3 rst = 1'b1;
    #1 check("async_rst", obs(), 5'b0_000_0);
    tick();
    tick();
    rst = 1'b0;
    check("rst_state", obs(), 5'b0_000_0);

    // No requests: main green held indefinitely
    for (int i = 1; i <= 100; i++) begin
      tick();
      push("idle_main", 1'b0, 3'd0, 1'b0);
    end

    // Single-cycle car pulse after edge 1, full auto cycle from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("auto_start", obs(), 5'b0_000_0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      push("auto_cycle", 1'b0, seq_phase(k),
           (k >= 4) && (k < T_MG_MIN + T_Y + T_AR));
      bus.car_sensor = (k == 1);
    end

    // Short man_btn glitch is rejected
    bus.man_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      push("btn_glitch", 1'b0, 3'd0, 1'b0);
      if (i == 3) bus.man_btn = 1'b0;
    end

    // Held man_btn enters manual on the LAT-th edge, phase frozen
    bus.man_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      push("btn_enter", (i >= LAT), 3'd0, 1'b0);
      if (i == 10) bus.man_btn = 1'b0;
    end

    // Six manual steps wrap back to 000, then nothing moves while idle
    exp_ph = 3'd0;
    for (int p = 0; p < 6; p++) press_step();
    for (int i = 1; i <= 50; i++) begin
      tick();
      push("man_idle", 1'b1, 3'd0, 1'b0);
    end

    // Step to 001, then coincident toggle+step: toggle wins, auto restarts in 001
    press_step();
    bus.man_btn  = 1'b1;
    bus.man_step = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i < LAT) push("btn_step_same", 1'b1, 3'd1, 1'b0);
      else         push("auto_restart", 1'b0, seq_phase(i - LAT + T_MG_MIN), 1'b0);
      if (i == 8) begin
        bus.man_btn  = 1'b0;
        bus.man_step = 1'b0;
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
